gpio_cfg_loader: RTL

Sequencer that programs the user-area GPIO pad control blocks after reset or on firmware request. It reads one configuration word per pad from the housekeeping register file and shifts all words, MSB first, into the daisy-chained GPIO control blocks over a serial clock/data pair. It then pulses `serial_load` so every pad applies its new mode at once. It sits between the housekeeping register bank and the `mprj_io` pad control chain.

---
 rtl/gpio_cfg_pkg.sv | 42 ++++
 rtl/gpio_cfg_bitclk.sv | 46 ++++
 rtl/gpio_cfg_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gpio_cfg_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cfg_pkg : shared state encoding and pad-word constants for the loader
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package gpio_cfg_pkg;

  localparam int GPIO_NUM_IO   = 38;
  localparam int GPIO_CFG_BITS = 13;

  // Field positions inside one pad configuration word
  localparam int GPIO_MGMT_EN_BIT  = 0;
  localparam int GPIO_OUT_DIS_BIT  = 1;
  localparam int GPIO_HOLD_OVR_BIT = 2;
  localparam int GPIO_INP_DIS_BIT  = 3;
  localparam int GPIO_IB_MODE_BIT  = 4;
  localparam int GPIO_ANA_EN_BIT   = 5;
  localparam int GPIO_ANA_SEL_BIT  = 6;
  localparam int GPIO_ANA_POL_BIT  = 7;
  localparam int GPIO_SLOW_BIT     = 8;
  localparam int GPIO_TRIP_BIT     = 9;
  localparam int GPIO_DM_LSB       = 10;
  localparam int GPIO_DM_MSB       = 12;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_CAPTURE  = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_SHIFT_HI = 3'd4,
    S_LOAD     = 3'd5,
    S_DONE     = 3'd6
  } gpio_cfg_state_e;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_cfg_bitclk.sv
// -----------------------------------------------------------------------------
// gpio_cfg_bitclk : half-period divider, ticks on the last cycle of each phase
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gpio_cfg_bitclk
  import gpio_cfg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CW     = clog2_min1(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reloaded on every phase entry, then counts down and parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/gpio_cfg_loader.sv
// -----------------------------------------------------------------------------
// gpio_cfg_loader : fetches one word per pad and shifts it into the GPIO chain
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gpio_cfg_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_IO   = GPIO_NUM_IO,
  parameter int CFG_BITS = GPIO_CFG_BITS,
  parameter int CLK_DIV  = 2
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [clog2_min1(NUM_IO)-1:0]   cfg_addr,
  input  logic [CFG_BITS-1:0]             cfg_data,
  output logic                            serial_clock,
  output logic                            serial_data,
  output logic                            serial_load
);

  localparam int            PW       = clog2_min1(NUM_IO);
  localparam int            BW       = clog2_min1(CFG_BITS);
  localparam logic [PW-1:0] PAD_LAST = PW'(NUM_IO - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);

  gpio_cfg_state_e     state_q, state_d;
  logic [PW-1:0]       pad_q, pad_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CFG_BITS-1:0] sreg_q, sreg_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sclk_q, sclk_d;
  logic sdat_q, sdat_d;
  logic sload_q, sload_d;

  logic phase_restart;
  logic phase_tick;

  // Any state change starts a fresh divider period.
  assign phase_restart = (state_d != state_q);

  gpio_cfg_bitclk #(
    .CLK_DIV (CLK_DIV)
  ) u_bitclk (
    .clock     (clock),
    .resetn    (resetn),
    .restart_i (phase_restart),
    .tick_o    (phase_tick)
  );

  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pad_d   = PAD_LAST;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        sreg_d  = cfg_data;
        bit_d   = BIT_LAST;
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (phase_tick) begin
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (phase_tick) begin
          sreg_d = sreg_q << 1;
          if (bit_q != '0) begin
            bit_d   = bit_q - BW'(1);
            state_d = S_SHIFT_LO;
          end else if (pad_q != '0) begin
            pad_d   = pad_q - PW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (phase_tick) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with it once registered.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    sclk_d  = (state_d == S_SHIFT_HI);
    sload_d = (state_d == S_LOAD);
    sdat_d  = 1'b0;
    if ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) begin
      sdat_d = sreg_d[CFG_BITS-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pad_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      sload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      sload_q <= sload_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_addr     = pad_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdat_q;
  assign serial_load  = sload_q;

endmodule

`default_nettype wire
